// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the SIMD AES decode stage.
// Builds scalar and lane-replicated vector immediates behind a valid/ready register.
module imm_gen_pipe #(
    parameter int XLEN         = 32,
    parameter int LANES        = 4,
    parameter int LANE_W       = 8,
    parameter int BRANCH_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:4]                opcode,
    input  logic [0:14]               instr_p1,
    input  logic [0:9]                instr_p2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:XLEN-1]           imm,
    output logic [0:LANES*LANE_W-1]   vimm,
    output logic                      is_vec,
    output logic                      illegal
);

    localparam int VW = LANES * LANE_W;

    logic              accept;
    logic              op_u, op_l, op_b, op_w, op_v;
    logic [0:16]       f_long;
    logic [0:11]       f_br;
    logic [0:LANE_W-1] lane, slane;
    logic [0:XLEN-1]   imm_d;
    logic [0:VW-1]     vimm_d;
    logic              vec_d, ill_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign op_u = (opcode == 5'b10111) || (opcode == 5'b10010);
    assign op_l = (opcode == 5'b01000);
    assign op_b = (opcode == 5'b11000);
    assign op_w = (opcode == 5'b00100);
    assign op_v = (opcode == 5'b10011);

    always_comb begin
        f_long = {instr_p1[0:6], instr_p2};
        f_br   = {instr_p1[0], instr_p2[4], instr_p1[1:6], instr_p2[0:3]};
        lane   = instr_p2[10-LANE_W:9];
        imm_d  = '0;
        vec_d  = 1'b0;
        ill_d  = 1'b0;
        unique case (1'b1)
            op_u: imm_d[XLEN-10:XLEN-1] = instr_p2;
            op_l: begin
                imm_d = {XLEN{f_long[0]}};
                imm_d[XLEN-17:XLEN-1] = f_long;
            end
            op_b: begin
                imm_d = {XLEN{f_br[0]}};
                if (BRANCH_SHIFT != 0)
                    imm_d[XLEN-13:XLEN-1] = {f_br, 1'b0};
                else
                    imm_d[XLEN-12:XLEN-1] = f_br;
            end
            op_w: begin
                imm_d = {XLEN{instr_p1[0]}};
                imm_d[XLEN-15:XLEN-1] = instr_p1;
            end
            op_v: begin
                imm_d[XLEN-LANE_W:XLEN-1] = lane;
                vec_d = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase
        // vector format leaves the lane in the low bits, so one path covers both
        slane  = imm_d[XLEN-LANE_W:XLEN-1];
        vimm_d = ill_d ? '0 : {LANES{slane}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            imm       <= '0;
            vimm      <= '0;
            is_vec    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            imm       <= imm_d;
            vimm      <= vimm_d;
            is_vec    <= vec_d;
            illegal   <= ill_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: default instance plus a BRANCH_SHIFT=1 copy.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] vimm;
        logic        is_vec;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [4:0]  opcode;
    logic [14:0] p1;
    logic [9:0]  p2;
    logic        in_ready, out_valid, is_vec, illegal;
    logic [31:0] imm, vimm;
    logic        in_ready_b, out_valid_b, is_vec_b, illegal_b;
    logic [31:0] imm_b, vimm_b;

    exp_t q[$];
    exp_t nxt;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .instr_p1(p1), .instr_p2(p2),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .vimm(vimm), .is_vec(is_vec), .illegal(illegal)
    );

    imm_gen_pipe #(.BRANCH_SHIFT(1)) u_dut_bs (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .opcode(opcode), .instr_p1(p1), .instr_p2(p2),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .imm(imm_b), .vimm(vimm_b), .is_vec(is_vec_b), .illegal(illegal_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input int unsigned f, input int n);
        longint x;
        x = longint'(f);
        if (((f >> (n - 1)) & 1) != 0) x = x - (longint'(1) << n);
        return 32'(x);
    endfunction

    // Numeric view: field bit 0 (MSB) of P1 is p1[14], of P2 is p2[9]
    function automatic exp_t model(input logic [4:0] op, input logic [14:0] a,
                                   input logic [9:0] b);
        exp_t e;
        e = '0;
        case (op)
            5'b10111, 5'b10010: e.imm = {22'd0, b};
            5'b01000: e.imm = sext({15'd0, a[14:8], b}, 17);
            5'b11000: e.imm = sext({20'd0, a[14], b[5], a[13:8], b[9:6]}, 12);
            5'b00100: e.imm = sext({17'd0, a}, 15);
            5'b10011: begin
                e.imm    = {24'd0, b[7:0]};
                e.is_vec = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
        if (!e.illegal) e.vimm = {4{e.imm[7:0]}};
        return e;
    endfunction

    // Called just after a negedge with inputs already driven
    task automatic tick();
        #1;
        if (out_valid && q.size() != 0) begin
            check("imm", imm, q[0].imm);
            check("vimm", vimm, q[0].vimm);
            check("is_vec", is_vec, q[0].is_vec);
            check("illegal", illegal, q[0].illegal);
        end
        if (out_valid && out_ready && !flush && !rst && q.size() != 0)
            void'(q.pop_front());
        if (in_valid && in_ready && !flush && !rst)
            q.push_back(nxt);
        @(posedge clk);
        if (rst || flush) q.delete();
        @(negedge clk);
        #1;
        check("occ", out_valid, q.size() != 0);
    endtask

    task automatic drive(input logic [4:0] op, input logic [14:0] a,
                         input logic [9:0] b);
        opcode = op;
        p1 = a;
        p2 = b;
        nxt = model(op, a, b);
    endtask

    task automatic send(input logic [4:0] op, input logic [14:0] a,
                        input logic [9:0] b);
        drive(op, a, b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [4:0] ops [8];

    initial begin
        ops = '{5'b10111, 5'b10010, 5'b01000, 5'b11000,
                5'b00100, 5'b10011, 5'b11111, 5'b00000};
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        drive(5'b00100, 15'h7FFF, 10'h3FF);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_imm", imm, 32'h0);
        check("rst_vimm", vimm, 32'h0);
        check("rst_flags", {is_vec, illegal}, 2'b00);
        check("rst_in_ready", in_ready, 1'b1);

        send(5'b10111, 15'h0, 10'h3FF);
        check("iu_imm", imm, 32'h000003FF);
        check("iu_valid", {out_valid, illegal}, 2'b10);
        send(5'b00100, 15'h4000, 10'h0);
        check("iw_imm", imm, 32'hFFFFC000);
        send(5'b01000, 15'h4000, 10'h0);
        check("il_imm", imm, 32'hFFFF0000);
        send(5'b11000, 15'h0, 10'h020);
        check("br_imm", imm, 32'h00000400);
        check("br_shift_imm", imm_b, 32'h00000800);
        send(5'b10011, 15'h0, 10'h0A5);
        check("vec_vimm", vimm, 32'hA5A5A5A5);
        check("vec_imm", imm, 32'h000000A5);
        check("vec_is_vec", is_vec, 1'b1);
        send(5'b11111, 15'h7FFF, 10'h3FF);
        check("ill_flag", illegal, 1'b1);
        check("ill_imm", imm, 32'h0);
        tick();

        // backpressure: A held while B waits
        send(5'b10111, 15'h0, 10'h111);
        out_ready = 1'b0;
        drive(5'b10111, 15'h0, 10'h222);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_hold", imm, 32'h111);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_b", imm, 32'h222);
        tick();

        // flush drops held entry and simultaneous input
        send(5'b00100, 15'h1234, 10'h0);
        drive(5'b10111, 15'h0, 10'h155);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        tick();

        // reset in the middle of a stall
        send(5'b00100, 15'h7FFF, 10'h0);
        out_ready = 1'b0;
        drive(5'b10011, 15'h0, 10'h0FF);
        in_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("rst2_state", {out_valid, is_vec, illegal}, 3'b000);
        check("rst2_imm", imm, 32'h0);
        check("rst2_vimm", vimm, 32'h0);

        for (int i = 0; i < 60; i++) begin
            drive(ops[$urandom_range(0, 7)], 15'($urandom), 10'($urandom));
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the SIMD AES core decode stage.
- Takes the opcode and the two instruction immediate fields (P1, P2) and produces a sign- or zero-extended scalar immediate plus a lane-replicated vector immediate.
- Adds a valid/ready pipeline register with flush and an illegal-format flag.
- Sits between instruction fetch/split and the register-read/execute stage.
- Field bit 0 is the MSB in every vector.

Parameters:
- XLEN, 32, scalar immediate width; must be >= 17.
- LANES, 4, number of SIMD lanes in the vector immediate.
- LANE_W, 8, bits per lane; must be <= 10.
- BRANCH_SHIFT, 0, if 1 the branch-format immediate is shifted left by 1 before extension (halfword-aligned targets).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard the held entry (pipeline redirect)
- in_valid  in  1  input fields valid
- in_ready  out  1  block can accept input this cycle
- opcode  in  5  [0:4] instruction opcode
- instr_p1  in  15  [0:14] immediate field P1
- instr_p2  in  10  [0:9] immediate field P2
- out_valid  out  1  outputs hold a valid result
- out_ready  in  1  consumer accepts result
- imm  out  XLEN  [0:XLEN-1] scalar immediate
- vimm  out  LANES*LANE_W  [0:LANES*LANE_W-1] vector immediate
- is_vec  out  1  result came from the vector-broadcast format
- illegal  out  1  opcode has no immediate format

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, imm=0, vimm=0, is_vec=0, illegal=0. Reset overrides flush and any transfer in the same cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; the result registers on that edge.
  - Latency 1 cycle; throughput 1 per cycle with no bubble when out_ready stays high.
- Stall: when out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Flush:
  - flush=1 clears out_valid next edge and drops any simultaneous input, even if in_valid && in_ready.
  - Data registers may keep stale values; consumers qualify on out_valid.
- Single pipeline register holding a two-state entry (EMPTY/FULL, encoded as out_valid):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept while out_ready (replace).
  - FULL -> EMPTY on out_ready without accept.
  - Any state -> EMPTY on flush or rst.
- Format decode, computed combinationally and registered on accept. Sign extension uses the MSB of the assembled field.
  - 10111, 10010 (I-unsigned): zero-extend P2 (10 bits).
  - 01000 (I-long): sign-extend {P1[0:6], P2} (17 bits).
  - 11000 (branch): sign-extend {P1[0], P2[4], P1[1:6], P2[0:3]} (12 bits). If BRANCH_SHIFT=1, append one 0 LSB first (13 bits).
  - 00100 (I-wide): sign-extend P1 (15 bits).
  - 10011 (vector broadcast):
    - lane = P2[10-LANE_W:9]; vimm = lane replicated LANES times; is_vec=1.
    - imm = zero-extended lane.
  - For every scalar format: vimm = imm[XLEN-LANE_W:XLEN-1] replicated; is_vec=0.
  - All other opcodes: imm=0, vimm=0, illegal=1. illegal=0 for every legal format.
- No X propagation: with in_valid=0, input fields are ignored and the registers do not change.

Test Plan:
- Reset: rst held 2 cycles with in_valid=1 -> out_valid=0, imm=0x00000000, in_ready=1 after release.
- Opcode 10111, P2=10'h3FF -> next cycle out_valid=1, imm=0x000003FF, illegal=0. Opcode 00100, P1=15'h4000 -> imm=0xFFFFC000.
- Opcode 01000, P1[0:6]=7'b1000000, P2=0 -> imm=0xFFFF0000. Opcode 11000, P1=0, P2[4]=1, other bits 0 -> imm=0x00000400, and 0x00000800 with BRANCH_SHIFT=1.
- Opcode 10011, P2 low byte 0xA5, LANES=4, LANE_W=8 -> vimm=0xA5A5A5A5, is_vec=1, imm=0x000000A5. Opcode 11111 -> illegal=1, imm=0.
- Backpressure: accept A, out_ready=0 for 3 cycles while B is offered -> imm holds A and in_ready=0; raise out_ready -> B accepted and appears the following cycle, no loss or duplication.
- Flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, input dropped. rst asserted mid-stall -> all outputs return to reset values.
